load_store_unit: RTL and testbench

- Sits between the single-cycle Data_Path and the external data memory bus.
- Consumes the ALU address (ALUResult), WriteData and the store/load controls.
- Runs a req/ack bus transaction with byte enables and freezes the core with `stall` until the access completes.
- Returns sign- or zero-extended ReadData to the result mux, and flags misaligned accesses instead of issuing them.

---
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: bridges the single-cycle core to a req/ack data-memory bus.
// Latency: aligned access stalls k+1 cycles for an ack k cycles after bus_req; misaligned stalls 1 cycle.
// Backpressure: holds bus_req and all bus outputs until bus_ack; freezes the core via stall meanwhile.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_read, MemWrite[1:0], ld_size[1:0], ld_unsigned, ALUResult[31:0], WriteData[31:0]  - core side
//   ReadData[31:0], stall, misalign, bus_err                                            - core side
//   bus_req, bus_we, bus_addr[31:0], bus_be[3:0], bus_wdata[31:0], bus_rdata[31:0], bus_ack - memory bus
//
// Optional feature: define LSU_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES
// without an ack (bus_err pulse, ReadData cleared). Undefined: BUSY waits forever, bus_err = 0.

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic [1:0]  MemWrite,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic [31:0] rdata_q;
    logic        misalign_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    // Load shape is latched at request time so extraction does not depend on
    // the core keeping its inputs steady through BUSY.
    logic [1:0]  ld_size_q;
    logic        ld_uns_q;
    logic [1:0]  lane_q;

    logic        is_store;
    logic        acc;
    logic        sz_byte, sz_half, sz_word;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [1:0]  ld_size_d;
    logic [31:0] lane;
    logic [31:0] ext;

    // Access decode; a store wins over a simultaneous load.
    always_comb begin
        is_store = (MemWrite != 2'b00);
        acc      = mem_read | is_store;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        if (is_store) begin
            case (MemWrite)
                2'b01:   sz_word = 1'b1;
                2'b10:   sz_half = 1'b1;
                default: sz_byte = 1'b1;
            endcase
        end else begin
            case (ld_size)
                2'b00:   sz_byte = 1'b1;
                2'b01:   sz_half = 1'b1;
                default: sz_word = 1'b1;
            endcase
        end
        // Normalised so that the held size always selects word for ld_size=11.
        ld_size_d  = sz_byte ? 2'b00 : (sz_half ? 2'b01 : 2'b10);
        misaligned = (sz_word && (ALUResult[1:0] != 2'b00)) ||
                     (sz_half && ALUResult[0]);

        be_d    = 4'hF;
        wdata_d = WriteData;
        if (is_store && sz_half) begin
            be_d    = 4'b0011 << ALUResult[1:0];
            wdata_d = {2{WriteData[15:0]}};
        end else if (is_store && sz_byte) begin
            be_d    = 4'b0001 << ALUResult[1:0];
            wdata_d = {4{WriteData[7:0]}};
        end
    end

    // Lane extraction and extension of the returned word.
    always_comb begin
        lane = bus_rdata >> {lane_q, 3'b000};
        case (ld_size_q)
            2'b00:   ext = ld_uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   ext = ld_uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             bus_err_q;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'h0;
            wdata_q    <= 32'h0;
            ld_size_q  <= 2'b00;
            ld_uns_q   <= 1'b0;
            lane_q     <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            tmo_q      <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (acc) begin
                        if (misaligned) begin
                            // Never reaches the bus; ReadData and memory untouched.
                            state_q    <= DONE;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q   <= BUSY;
                            req_q     <= 1'b1;
                            we_q      <= is_store;
                            addr_q    <= {ALUResult[31:2], 2'b00};
                            be_q      <= be_d;
                            wdata_q   <= wdata_d;
                            ld_size_q <= ld_size_d;
                            ld_uns_q  <= ld_unsigned;
                            lane_q    <= ALUResult[1:0];
`ifdef LSU_TIMEOUT_EN
                            tmo_q     <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        if (!we_q) begin
                            rdata_q <= ext;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        req_q     <= 1'b0;
                        state_q   <= DONE;
                        bus_err_q <= 1'b1;
                        rdata_q   <= 32'h0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
`endif
                    end
                end
                // Commit cycle: any request seen here belongs to the retiring instruction.
                default: state_q <= IDLE;
            endcase
        end
    end

    // Released during DONE so the core commits exactly once; forced low in reset.
    assign stall = reset && (((state_q == IDLE) && acc) || (state_q == BUSY));

    assign ReadData  = rdata_q;
    assign misalign  = misalign_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic [1:0]  MemWrite;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .MemWrite    (MemWrite),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .stall       (stall),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Store with the ack two cycles after bus_req rises: stall high 3 cycles, then low.
    task automatic do_store(input string tag, input logic [1:0] mw, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        MemWrite = mw; mem_read = rd; ld_size = 2'b10; ALUResult = addr; WriteData = wd;
        #1;
        chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
        step();
        chk({tag, "_req"},   32'(bus_req), 32'd1);
        chk({tag, "_we"},    32'(bus_we), 32'd1);
        chk({tag, "_be"},    32'(bus_be), 32'(exp_be));
        chk({tag, "_wdata"}, bus_wdata, exp_wd);
        chk({tag, "_addr"},  bus_addr, {addr[31:2], 2'b00});
        chk({tag, "_stall_c1"}, 32'(stall), 32'd1);
        step();
        chk({tag, "_stall_c2"}, 32'(stall), 32'd1);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_req_drop"},   32'(bus_req), 32'd0);
        MemWrite = 2'b00; mem_read = 1'b0;
        step();
        chk({tag, "_stall_idle"}, 32'(stall), 32'd0);
    endtask

    // Load acked in the first BUSY cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
        mem_read = 1'b1; MemWrite = 2'b00; ld_size = sz; ld_unsigned = uns; ALUResult = addr;
        #1;
        chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
        step();
        chk({tag, "_req"},  32'(bus_req), 32'd1);
        chk({tag, "_we"},   32'(bus_we), 32'd0);
        chk({tag, "_be"},   32'(bus_be), 32'hF);
        chk({tag, "_addr"}, bus_addr, {addr[31:2], 2'b00});
        bus_ack = 1'b1; bus_rdata = rdata;
        step();
        bus_ack = 1'b0;
        chk({tag, "_rdata"}, ReadData, exp);
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        mem_read = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0; mem_read = 1'b1; MemWrite = 2'b00; ld_size = 2'b10; ld_unsigned = 1'b0;
        ALUResult = 32'h0; WriteData = 32'h0; bus_rdata = 32'h0; bus_ack = 1'b0;
        #12;
        // Reset state; stall stays low even with a pending request.
        chk("rst_stall",    32'(stall), 32'd0);
        chk("rst_rdata",    ReadData, 32'h0);
        chk("rst_req",      32'(bus_req), 32'd0);
        chk("rst_we",       32'(bus_we), 32'd0);
        chk("rst_be",       32'(bus_be), 32'd0);
        chk("rst_addr",     bus_addr, 32'h0);
        chk("rst_wdata",    bus_wdata, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_bus_err",  32'(bus_err), 32'd0);
        mem_read = 1'b0;
        reset = 1'b1;
        step();

        // Stray ack while idle is ignored.
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        step();
        bus_ack = 1'b0;
        chk("idle_ack_rdata", ReadData, 32'h0);
        chk("idle_ack_req",   32'(bus_req), 32'd0);

        do_store("st_word", 2'b01, 1'b0, 32'h0000_0100, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE);
        do_load("ld_b_s", 32'h0000_0103, 2'b00, 1'b0, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("ld_b_u", 32'h0000_0103, 2'b00, 1'b1, 32'h80FF_0000, 32'h0000_0080);
        do_store("st_half", 2'b10, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("st_byte", 2'b11, 1'b0, 32'h0000_0301, 32'h0000_0055, 4'b0010, 32'h5555_5555);
        // Store takes priority over a simultaneous load.
        do_store("st_prio", 2'b01, 1'b1, 32'h0000_0400, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);
        do_load("ld_h_s", 32'h0000_0102, 2'b01, 1'b0, 32'h8001_1234, 32'hFFFF_8001);
        do_load("ld_w11", 32'h0000_0108, 2'b11, 1'b0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

        // Misaligned word load: no request, one-cycle stall and misalign pulse.
        mem_read = 1'b1; ld_size = 2'b10; ALUResult = 32'h0000_0105;
        #1;
        chk("mis_stall_c0", 32'(stall), 32'd1);
        step();
        chk("mis_pulse",     32'(misalign), 32'd1);
        chk("mis_no_req",    32'(bus_req), 32'd0);
        chk("mis_stall_dn",  32'(stall), 32'd0);
        chk("mis_rdata",     ReadData, 32'hA5A5_0F0F);
        mem_read = 1'b0;
        step();
        chk("mis_pulse_end", 32'(misalign), 32'd0);

        // Misaligned halfword store is suppressed.
        MemWrite = 2'b10; ALUResult = 32'h0000_0201; WriteData = 32'h0000_7777;
        step();
        chk("mis_st_pulse",  32'(misalign), 32'd1);
        chk("mis_st_no_req", 32'(bus_req), 32'd0);
        MemWrite = 2'b00;
        step();

        // Reset while BUSY: bus_req falls immediately; a late ack is ignored.
        mem_read = 1'b1; ld_size = 2'b10; ALUResult = 32'h0000_0100;
        step();
        chk("rb_req_busy", 32'(bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rb_req_async", 32'(bus_req), 32'd0);
        chk("rb_stall",     32'(stall), 32'd0);
        mem_read = 1'b0;
        reset = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_ack = 1'b0;
        chk("rb_late_ack_rdata", ReadData, 32'h0);
        chk("rb_idle_req",       32'(bus_req), 32'd0);
        chk("rb_idle_stall",     32'(stall), 32'd0);
        do_load("ld_after_rst", 32'h0000_0200, 2'b10, 1'b0, 32'h1122_3344, 32'h1122_3344);

`ifdef LSU_TIMEOUT_EN
        // No ack: abort after 4 BUSY cycles.
        mem_read = 1'b1; ld_size = 2'b10; ALUResult = 32'h0000_0300;
        step();
        step();
        step();
        step();
        chk("tmo_still_busy", 32'(stall), 32'd1);
        chk("tmo_no_err_yet", 32'(bus_err), 32'd0);
        step();
        chk("tmo_err",   32'(bus_err), 32'd1);
        chk("tmo_rdata", ReadData, 32'h0);
        chk("tmo_stall", 32'(stall), 32'd0);
        chk("tmo_req",   32'(bus_req), 32'd0);
        mem_read = 1'b0;
        step();
        chk("tmo_err_end", 32'(bus_err), 32'd0);
`else
        chk("no_tmo_bus_err", 32'(bus_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
